// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter granting one of four byte sources to a serial transmitter,
// holding the owner until its packet ends, the frame drains and the idle gap expires.
module serial_tx_arbiter #(
  parameter int GAP_CYCLES = 12,
  parameter int MAX_LEN    = 64
) (
  input  logic        clk12,
  input  logic        rst_n,
  input  logic [3:0]  src_req,
  input  logic [31:0] src_data,
  input  logic [3:0]  src_valid,
  input  logic [3:0]  src_last,
  output logic [3:0]  src_ready,
  output logic [7:0]  sbyte,
  output logic        sbyte_rdy,
  input  logic        ack,
  input  logic        end_of_send,
  output logic [1:0]  grant,
  output logic        grant_valid,
  output logic        len_err
);

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, GAP} state_t;

  state_t        r_state;
  logic [1:0]    r_grant;
  logic [1:0]    r_last_grant;
  logic          r_grant_valid;
  logic [7:0]    r_len_cnt;
  logic [GW-1:0] r_gap_cnt;

  logic [7:0]    w_src_byte [4];
  logic [1:0]    w_winner;
  logic          w_send;
  logic          w_take;
  logic          w_len_hit;
  logic          w_sel_last;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign w_src_byte[gi] = src_data[8*gi +: 8];
    end
  endgenerate

  // Scan downward so the last hit is the nearest requester after last_grant.
  always_comb begin
    logic [1:0] cand;
    cand     = 2'd0;
    w_winner = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = r_last_grant + 2'(k);
      if (src_req[cand]) w_winner = cand;
    end
  end

  assign w_send     = (r_state == SEND);
  assign w_take     = w_send & ack;
  assign w_sel_last = src_last[r_grant];
  assign w_len_hit  = (({1'b0, r_len_cnt} + 9'd1) == 9'(MAX_LEN));

  assign sbyte       = w_send ? w_src_byte[r_grant] : 8'h00;
  assign sbyte_rdy   = w_send & src_valid[r_grant];
  assign src_ready   = w_take ? (4'b0001 << r_grant) : 4'b0000;
  assign len_err     = w_take & ~w_sel_last & w_len_hit;
  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;

  always_ff @(posedge clk12 or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_grant       <= 2'd0;
      r_last_grant  <= 2'd3;
      r_grant_valid <= 1'b0;
      r_len_cnt     <= 8'd0;
      r_gap_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|src_req) begin
            r_grant       <= w_winner;
            r_last_grant  <= w_winner;
            r_grant_valid <= 1'b1;
            r_len_cnt     <= 8'd0;
            r_state       <= SEND;
          end else begin
            r_grant_valid <= 1'b0;
          end
        end
        SEND: begin
          // end_of_send here belongs to an earlier byte and is deliberately ignored.
          if (ack) begin
            r_len_cnt <= r_len_cnt + 8'd1;
            if (w_sel_last || w_len_hit) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (end_of_send) begin
            r_grant_valid <= 1'b0;
            if (GAP_CYCLES == 0) begin
              r_state <= IDLE;
            end else begin
              r_gap_cnt <= GW'(GAP_CYCLES);
              r_state   <= GAP;
            end
          end
        end
        GAP: begin
          r_gap_cnt <= r_gap_cnt - GW'(1);
          if (r_gap_cnt <= GW'(1)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Randomized bench: per-source byte queues and a timeline model of grant, drain and gap
// predict every cycle's handshake outputs of serial_tx_arbiter.
module tb_serial_tx_arbiter;

  localparam int GAP  = 12;
  localparam int MAXL = 64;
  localparam int NCYC = 8000;

  logic        clk12 = 1'b0;
  logic        rst_n;
  logic [3:0]  src_req, src_valid, src_last, src_ready;
  logic [31:0] src_data;
  logic [7:0]  sbyte;
  logic        sbyte_rdy, ack, end_of_send, grant_valid, len_err;
  logic [1:0]  grant;

  serial_tx_arbiter #(.GAP_CYCLES(GAP), .MAX_LEN(MAXL)) dut (
    .clk12(clk12), .rst_n(rst_n), .src_req(src_req), .src_data(src_data),
    .src_valid(src_valid), .src_last(src_last), .src_ready(src_ready),
    .sbyte(sbyte), .sbyte_rdy(sbyte_rdy), .ack(ack), .end_of_send(end_of_send),
    .grant(grant), .grant_valid(grant_valid), .len_err(len_err)
  );

  always #5 clk12 = ~clk12;

  // Source contents: {last, byte} per entry, front entry is what the source presents.
  logic [8:0] q [4][$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int owner = -1;      // model owner, -1 when nobody holds the transmitter
  int last_g = 3;
  int cnt = 0;         // bytes of the current packet already accepted
  int idle_from = 0;   // first cycle in which arbitration may happen again
  bit sending = 1'b0;
  bit did_rst = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push_pkt(input int s, input int len);
    for (int k = 0; k < len; k++) q[s].push_back({(k == len - 1), 8'($urandom)});
  endtask

  task automatic drive_sources();
    for (int i = 0; i < 4; i++) begin
      if (q[i].size() > 0) begin
        // The owner may drop its request mid-packet; that must not matter.
        src_req[i]         = !(i == owner && sending && ($urandom % 2 == 0));
        src_data[8*i +: 8] = q[i][0][7:0];
        src_last[i]        = q[i][0][8];
        src_valid[i]       = ($urandom % 5 != 0);
      end else begin
        src_req[i]         = 1'b0;
        src_data[8*i +: 8] = 8'($urandom);
        src_last[i]        = 1'b0;
        src_valid[i]       = 1'b0;
      end
    end
  endtask

  task automatic model_check();
    logic [31:0] exp_ready;
    check("grant_valid", {31'd0, grant_valid}, {31'd0, owner >= 0});
    if (owner >= 0) check("grant", {30'd0, grant}, 32'(owner));
    if (sending) begin
      exp_ready = ack ? (32'd1 << owner) : 32'd0;
      check("sbyte_rdy", {31'd0, sbyte_rdy}, {31'd0, src_valid[owner]});
      if (src_valid[owner]) check("sbyte", {24'd0, sbyte}, {24'd0, q[owner][0][7:0]});
      check("src_ready", {28'd0, src_ready}, exp_ready);
      check("len_err", {31'd0, len_err},
            {31'd0, ack && !q[owner][0][8] && (cnt + 1 == MAXL)});
    end else begin
      check("sbyte_rdy", {31'd0, sbyte_rdy}, 32'd0);
      check("src_ready", {28'd0, src_ready}, 32'd0);
      check("len_err", {31'd0, len_err}, 32'd0);
    end
  endtask

  task automatic model_advance();
    logic lastb;
    if (sending) begin
      if (ack && q[owner].size() > 0) begin
        lastb = q[owner][0][8];
        void'(q[owner].pop_front());
        cnt++;
        if (lastb || cnt == MAXL) begin
          sending = 1'b0;
          $display("pkt src=%0d bytes=%0d truncated=%0d cyc=%0d", owner, cnt, !lastb, cyc);
        end
      end
    end else if (owner >= 0) begin
      if (end_of_send) begin
        owner     = -1;
        idle_from = cyc + GAP + 1;
      end
    end else if (cyc >= idle_from && src_req != 4'd0) begin
      for (int k = 1; k <= 4; k++) begin
        if (src_req[(last_g + k) % 4]) begin
          owner = (last_g + k) % 4;
          break;
        end
      end
      last_g  = owner;
      sending = 1'b1;
      cnt     = 0;
    end
  endtask

  // One clock of stimulus and checking, entered just after a falling edge.
  task automatic step();
    for (int i = 0; i < 4; i++) begin
      if (q[i].size() == 0 && ($urandom % 3 == 0))
        push_pkt(i, ($urandom % 8 == 0) ? 70 : int'($urandom_range(1, 4)));
    end
    drive_sources();
    end_of_send = ($urandom % 4 == 0);
    #1;
    ack = sbyte_rdy && ($urandom % 3 != 0);
    #1;
    model_check();
    model_advance();
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk12);
    #2 rst_n = 1'b0;
    #1;
    check("rst_sbyte_rdy", {31'd0, sbyte_rdy}, 32'd0);
    check("rst_grant_valid", {31'd0, grant_valid}, 32'd0);
    check("rst_src_ready", {28'd0, src_ready}, 32'd0);
    check("rst_grant", {30'd0, grant}, 32'd0);
    for (int i = 0; i < 4; i++) q[i].delete();
    push_pkt(0, 2);
    push_pkt(3, 2);
    ack = 1'b0;
    end_of_send = 1'b0;
    @(negedge clk12);
    rst_n     = 1'b1;
    owner     = -1;
    sending   = 1'b0;
    last_g    = 3;
    cnt       = 0;
    idle_from = 0;
    did_rst   = 1'b1;
    step();
    @(negedge clk12);
    step();
    check("rearb_after_rst", {30'd0, grant}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    src_req = '0; src_valid = '0; src_last = '0; src_data = '0;
    ack = 1'b0; end_of_send = 1'b0;
    repeat (2) @(negedge clk12);
    check("reset_grant_valid", {31'd0, grant_valid}, 32'd0);
    check("reset_sbyte_rdy", {31'd0, sbyte_rdy}, 32'd0);
    check("reset_src_ready", {28'd0, src_ready}, 32'd0);
    check("reset_grant", {30'd0, grant}, 32'd0);
    check("reset_len_err", {31'd0, len_err}, 32'd0);
    // Every source starts with a one-byte packet so the rotation is exercised at once.
    for (int i = 0; i < 4; i++) push_pkt(i, 1);
    @(negedge clk12);
    rst_n = 1'b1;
    step();
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk12);
      step();
      if (!did_rst && cyc > 3000 && sending && cnt == 1) do_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_tx_arbiter.md
SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

Interface
REQ-001 Parameters SHALL be: GAP_CYCLES, 12, idle clocks inserted after each packet's final end_of_send; MAX_LEN, 64, maximum bytes per packet (1..255).
REQ-002 clk12  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 src_req  input  4  source i has a packet pending.
REQ-005 src_data  input  32  byte of source i at bits [8i+7:8i].
REQ-006 src_valid  input  4  source i byte valid.
REQ-007 src_last  input  4  source i byte is the final byte of its packet.
REQ-008 src_ready  output  4  one-hot or zero; bit i = byte of source i consumed this cycle.
REQ-009 sbyte  output  8  byte to the serial transmitter.
REQ-010 sbyte_rdy  output  1  sbyte valid.
REQ-011 ack  input  1  transmitter accepted sbyte this cycle.
REQ-012 end_of_send  input  1  one-cycle pulse when a transmitted frame completes.
REQ-013 grant  output  2  index of current owner.
REQ-014 grant_valid  output  1  an owner holds the transmitter.
REQ-015 len_err  output  1  one-cycle pulse: packet truncated at MAX_LEN.

Function
REQ-016 FSM states SHALL be IDLE, SEND, DRAIN, GAP.
REQ-017 IDLE: with any src_req high, winner = first requester scanning from (last_grant+1) mod 4 upward with wrap; grant/last_grant load winner, grant_valid=1, next state SEND (one-cycle arbitration latency).
REQ-018 IDLE with no src_req: remain; grant_valid=0, sbyte_rdy=0.
REQ-019 SEND: sbyte = src_data[grant] and sbyte_rdy = src_valid[grant], combinational pass-through.
REQ-020 SEND: src_ready[grant] = ack (other bits 0); byte counter len_cnt (8-bit) increments on each ack.
REQ-021 SEND, ack with src_last[grant]=1: next state DRAIN.
REQ-022 SEND, ack with len_cnt+1 == MAX_LEN and src_last[grant]=0: next state DRAIN, len_err pulses same cycle; remainder of packet stays with source.
REQ-023 end_of_send SHALL be ignored in SEND (it belongs to a previous byte, including one coinciding with ack).
REQ-024 DRAIN: sbyte_rdy=0, src_ready=0; on end_of_send, load gap counter with GAP_CYCLES and go GAP, or go IDLE directly when GAP_CYCLES=0.
REQ-025 GAP: counter decrements each cycle; on reaching 0 go IDLE; grant_valid=0 on GAP entry.
REQ-026 src_req deassertion by the owner mid-packet SHALL be ignored; only src_last or MAX_LEN ends a packet.
REQ-027 src_valid low in SEND SHALL hold sbyte_rdy low with no timeout.
REQ-028 grant SHALL hold its value until next arbitration; len_cnt clears on IDLE->SEND.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, sbyte_rdy=0, src_ready=0, grant=0, grant_valid=0, len_err=0, len_cnt=0, gap counter=0, last_grant=3 (source 0 highest priority first).
REQ-030 Reset mid-packet SHALL abort it with no further bytes presented; after release, arbitration restarts from last_grant=3.

Verification
REQ-031 Single source 2, 3-byte packet 0xA1,0xA2,0xA3 (last on 0xA3), ack one cycle after each sbyte_rdy -> grant=2, three src_ready[2] pulses, DRAIN until end_of_send, then exactly 12 GAP cycles before IDLE.
REQ-032 All four src_req held high, 1-byte packets -> grant sequence 0,1,2,3,0; no source granted twice while another waits.
REQ-033 Source 1 sends 70 bytes with no last, MAX_LEN=64 -> 64 acks, len_err pulse on 64th ack, then DRAIN; next grant to source 2 if requesting.
REQ-034 end_of_send pulsed in same cycle as ack of 2nd byte -> FSM stays SEND; DRAIN exits only on end_of_send after final byte.
REQ-035 rst_n low during SEND after 1 of 4 bytes -> sbyte_rdy=0 and grant_valid=0 in the same cycle; after release with src_req=4'b1001, grant=0.
REQ-036 GAP_CYCLES=0 build -> DRAIN goes to IDLE on end_of_send; new grant one cycle later.
